uart_tx_cfg: RTL
================

Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, successor to the fixed 6-bit, fixed-baud transmitter in the tester.
- Generic data width (5..9 bits).
- Baud divisor, parity mode and stop-bit count are set at run time and sampled at frame start.
- Uses a valid/ready handshake instead of a start pulse.
- Drives the tester's serial output pin. Upstream is the result formatter or a FIFO.

Parameters:
DATA_BITS, 8, payload width per frame; legal 5..9.
DIV_WIDTH, 16, width of baud divisor input and internal tick counter.

Ports:
in_clk  input  1  system clock
in_rst  input  1  synchronous reset, active-high
in_valid  input  1  payload valid
in_data  input  DATA_BITS  payload, transmitted LSB first
out_ready  output  1  block can accept a payload this cycle
in_divisor  input  DIV_WIDTH  clock cycles per bit; 0 treated as 1
in_parity  input  2  00 none, 01 even, 10 odd, 11 reserved (treated as none)
in_stop2  input  1  1 = two stop bits, 0 = one stop bit
out_busy  output  1  frame in progress
out_done  output  1  one-cycle pulse after the last stop bit
out_tx  output  1  serial line, idle high

Behaviour:
- Reset: one clock, synchronous, active-high (in_rst=1 at a rising edge of in_clk). While in_rst is asserted: out_tx=1, out_busy=0, out_done=0, out_ready=0. The state machine returns to IDLE and all counters clear.
- Reset mid-frame: the frame is aborted with no out_done pulse. out_tx=1 from the cycle after the reset edge.
- States:
  - IDLE: out_ready=1, out_tx=1. Handshake = in_valid & out_ready at a rising edge.
  - START: out_tx=0.
  - DATA: out_tx=shift_reg[0].
  - PARITY: out_tx=parity bit.
  - STOP: out_tx=1.
  - DONE: out_done=1, out_tx=1, out_ready=0.
- Transitions:
  - IDLE -> START on handshake.
  - START -> DATA after D cycles.
  - DATA -> DATA after each bit, until DATA_BITS bits have been sent; then -> PARITY if parity is enabled, else -> STOP.
  - PARITY -> STOP after D cycles.
  - STOP -> DONE after D cycles (1 stop bit) or 2*D cycles (2 stop bits).
  - DONE -> IDLE unconditionally after 1 cycle.
- On handshake, latch in_data, D = max(in_divisor,1), parity mode and stop count. Input changes during a frame have no effect.
- out_busy=1 in START, DATA, PARITY and STOP.
- Parity: even = XOR of the payload bits; odd = its inverse. Computed from the latched data.
- Timing: N = 1 + DATA_BITS + P + S, where P = 1 if parity is on else 0, and S = 1 or 2 stop bits.
  - Handshake at edge k.
  - The frame occupies cycles k+1 .. k+N*D.
  - out_done is high in cycle k+N*D+1.
  - out_ready is high again in cycle k+N*D+2.
- Back-to-back frames: minimum inter-frame idle is 2 cycles (the DONE cycle plus the IDLE handshake cycle). If in_valid is held high, the next frame starts with START in cycle k+N*D+3.
- Bit timer: counts 0..D-1 and wraps. A bit advances when the count equals D-1. The counter clears on every state entry.
- Bit counter width: clog2(DATA_BITS+1). The shift register shifts right once per DATA bit.
- out_tx is registered (glitch-free pin). Its value changes only on state or bit boundaries.
- No X on any output after the first reset cycle. The default state branch returns to IDLE.

Decomposition:
- Package uart_pkg:
  - parity_e enum (PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10).
  - tx_state_e enum (IDLE, START, DATA, PARITY, STOP, DONE).
  - Function frame_bits(data_bits, parity_on, stop2) returning N.
- Sub-module uart_baud_tick: a DIV_WIDTH counter with clear and divisor inputs, and a one-cycle tick output at count D-1. It is reused by the future uart_rx_cfg.

Test Plan:
1. DATA_BITS=8, divisor=4, parity=none, stop2=0, data=0x55, handshake at cycle 0 -> out_tx over cycles 1..40 is 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles. out_done=1 at cycle 41 only. out_ready=1 at cycle 42.
2. divisor=2, parity=even, data=0x07 -> parity bit = 1 at cycles 19..20. Repeat with parity=odd -> parity bit = 0. Stop bit high at cycles 21..22, out_done at cycle 23.
3. divisor=3, stop2=1, parity=none, data=0xFF -> stop high for 6 cycles (cycles 28..33), out_done at cycle 34. Changing in_divisor to 10 at cycle 5 does not alter any bit length.
4. in_valid held high with data 0xA1 then 0x3C, divisor=1 -> two frames. The second START is at cycle 13 (frame 1 N=10, done at 11, ready at 12). out_ready is low from cycle 1 to cycle 11.
5. in_rst=1 at cycle 15 of frame 1 (divisor=4, data=0x00) -> out_tx=1 from cycle 16. No out_done pulse. out_ready=0 during reset, 1 in the first cycle after reset is released.
6. in_divisor=0, DATA_BITS=8, no parity, stop2=0 -> behaves as divisor=1: frame occupies 10 cycles, out_done at cycle 11.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART blocks.
// Latency: n/a (types and a constant function only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } tx_state_e;

    // Number of bit slots in one frame: start + payload + optional parity + stop bits.
    function automatic int unsigned frame_bits(input int unsigned data_bits,
                                               input logic parity_on,
                                               input logic stop2);
        int unsigned n;
        n = 1 + data_bits + 1;
        if (parity_on) n = n + 1;
        if (stop2)     n = n + 1;
        return n;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..D-1 and pulses tick when the count reaches D-1 (D = max(divisor,1)).
// Latency: tick is combinational from the count; a cleared counter ticks D cycles after clear drops.
// Backpressure: none; clear holds the count at zero and suppresses tick.
module uart_baud_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] count;
    logic [DIV_WIDTH-1:0] last;

    // A divisor of zero behaves like one, so the terminal count is zero either way.
    assign last = (divisor == '0) ? '0 : divisor - DIV_WIDTH'(1);
    assign tick = !clear && (count == last);

    // Free-running counter that wraps on tick and is held at zero while cleared.
    always_ff @(posedge clk) begin
        if (rst || clear || tick) begin
            count <= '0;
        end else begin
            count <= count + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with run-time divisor, parity mode and stop-bit count, all latched at handshake.
// Latency: line drops to start bit the cycle after handshake; frame lasts N*D cycles, done pulse follows.
// Backpressure: out_ready is high only in IDLE; inputs are ignored for the rest of the frame.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 out_ready,
    input  logic [DIV_WIDTH-1:0] in_divisor,
    input  logic [1:0]           in_parity,
    input  logic                 in_stop2,
    output logic                 out_busy,
    output logic                 out_done,
    output logic                 out_tx
);

    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

    tx_state_e            state;
    logic [DATA_BITS-1:0] shift_reg;
    logic [CW-1:0]        bit_cnt;
    logic [DIV_WIDTH-1:0] div_q;
    logic                 par_on_q;
    logic                 par_bit_q;
    logic                 stop2_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 ready_q;
    logic                 tick;
    logic                 timer_clear;
    logic [CW-1:0]        stop_last;

    // The bit timer idles at zero outside the frame so START always gets a full bit period.
    assign timer_clear = (state == IDLE) || (state == DONE);
    assign stop_last   = {{(CW-1){1'b0}}, stop2_q};

    uart_baud_tick #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_tick (
        .clk     (in_clk),
        .rst     (in_rst),
        .clear   (timer_clear),
        .divisor (div_q),
        .tick    (tick)
    );

    // Frame sequencer; every output is registered so the pin only moves on bit boundaries.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            div_q     <= DIV_WIDTH'(1);
            par_on_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    if (in_valid && ready_q) begin
                        shift_reg <= in_data;
                        bit_cnt   <= '0;
                        div_q     <= (in_divisor == '0) ? DIV_WIDTH'(1) : in_divisor;
                        par_on_q  <= (in_parity == PAR_EVEN) || (in_parity == PAR_ODD);
                        par_bit_q <= (^in_data) ^ (in_parity == PAR_ODD);
                        stop2_q   <= in_stop2;
                        state     <= START;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        ready_q   <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        tx_q    <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (par_on_q) begin
                                state <= PARITY;
                                tx_q  <= par_bit_q;
                            end else begin
                                state <= STOP;
                                tx_q  <= 1'b1;
                            end
                        end else begin
                            shift_reg <= shift_reg >> 1;
                            tx_q      <= shift_reg[1];
                            bit_cnt   <= bit_cnt + CW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state   <= STOP;
                        tx_q    <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (bit_cnt == stop_last) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_tx    = tx_q;
    assign out_busy  = busy_q;
    assign out_done  = done_q;
    assign out_ready = ready_q;

endmodule
